// File: rtl/cache_controller_q_if.sv
// CPU-side request port, tag/state array strobes and ACE request/ready
// handshake of the queued cache line controller.
// master: the controller.  slave: the CPU / arrays / interconnect side.
interface cache_controller_q_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req_valid;
  logic              cpu_req_op;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cache_ready;
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_addr;
  logic              cache_hit;
  logic [2:0]        line_state;
  logic              read_req;
  logic              write_req;
  logic              invalid_req;
  logic              ace_ready;
  logic              write_from_cpu;
  logic              write_from_interconnect;
  logic              state_sel;
  logic [2:0]        new_state;
  logic              cache_complete;
  logic              cache_error;

  modport master (
    input  cpu_req_valid, cpu_req_op, cpu_req_addr, cache_hit, line_state, ace_ready,
    output cache_ready, lookup_valid, lookup_addr, read_req, write_req, invalid_req,
           write_from_cpu, write_from_interconnect, state_sel, new_state,
           cache_complete, cache_error
  );

  modport slave (
    output cpu_req_valid, cpu_req_op, cpu_req_addr, cache_hit, line_state, ace_ready,
    input  cache_ready, lookup_valid, lookup_addr, read_req, write_req, invalid_req,
           write_from_cpu, write_from_interconnect, state_sel, new_state,
           cache_complete, cache_error
  );
endinterface

// File: rtl/cache_controller_q.sv
// Queued cache line controller: CPU requests land in a QUEUE_DEPTH FIFO and
// are serviced one at a time (lookup, optional write-back, fill or upgrade,
// array update). Optional ACE wait timeout under `CACHE_CTRL_TIMEOUT_EN`.
module cache_controller_q #(
  parameter int ADDR_W      = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT_W   = 8
)(
  input  logic                clk,
  input  logic                reset,
  cache_controller_q_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

  localparam logic [2:0] ST_I  = 3'b000;
  localparam logic [2:0] ST_UD = 3'b001;
  localparam logic [2:0] ST_UC = 3'b010;
  localparam logic [2:0] ST_SD = 3'b011;

  typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, WB, FILL, INVAL, UPDATE, DONE} state_t;
  typedef logic [TIMEOUT_W-1:0] tmo_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr [QUEUE_DEPTH];
  logic              fifo_op   [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              push, pop, abort;

  assign bus.cache_ready = (count != FULL);
  assign push            = bus.cpu_req_valid && bus.cache_ready;
  // Pop only from IDLE, and only what was already queued (no bypass).
  assign pop             = (state_q == IDLE) && (count != '0);
  assign bus.lookup_addr = addr_q;

  // Request FIFO: storage, wrapping pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= bus.cpu_req_addr;
        fifo_op[wr_ptr]   <= bus.cpu_req_op;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Latch the head request for the duration of its service
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 1'b0;
      addr_q <= '0;
    end else if (pop) begin
      op_q   <= fifo_op[rd_ptr];
      addr_q <= fifo_addr[rd_ptr];
    end
  end

`ifdef CACHE_CTRL_TIMEOUT_EN
  tmo_t tmo_cnt, tmo_nxt;
  logic waiting;

  assign waiting = (state_q == WB) || (state_q == FILL) || (state_q == INVAL);
  assign tmo_nxt = tmo_cnt + tmo_t'(1);
  // Give up when this waiting cycle takes the counter to all-ones; a
  // completion arriving in that same cycle still wins.
  assign abort           = waiting && !bus.ace_ready && (&tmo_nxt);
  assign bus.cache_error = abort;

  // Wait counter: restarts on every entry into a wait state
  always_ff @(posedge clk) begin
    if (reset || !waiting || (state_d != state_q)) tmo_cnt <= '0;
    else                                           tmo_cnt <= tmo_nxt;
  end
`else
  assign abort           = 1'b0;
  assign bus.cache_error = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and array/ACE strobes
  always_comb begin
    state_d                     = state_q;
    bus.lookup_valid            = 1'b0;
    bus.read_req                = 1'b0;
    bus.write_req               = 1'b0;
    bus.invalid_req             = 1'b0;
    bus.write_from_cpu          = 1'b0;
    bus.write_from_interconnect = 1'b0;
    bus.state_sel               = 1'b0;
    bus.new_state               = ST_I;
    bus.cache_complete          = 1'b0;
    case (state_q)
      IDLE:   if (pop) state_d = LOOKUP;
      LOOKUP: begin
        bus.lookup_valid = 1'b1;
        state_d          = DECIDE;
      end
      DECIDE: begin
        // A hit on an Invalid line is a miss.
        if (bus.cache_hit && bus.line_state != ST_I) begin
          if (!op_q)                                               state_d = DONE;
          else if (bus.line_state == ST_UD || bus.line_state == ST_UC) state_d = UPDATE;
          else                                                     state_d = INVAL;
        end else if (bus.line_state == ST_UD || bus.line_state == ST_SD) begin
          state_d = WB;
        end else begin
          state_d = FILL;
        end
      end
      WB: begin
        bus.write_req = 1'b1;
        if (bus.ace_ready) begin
          bus.state_sel = 1'b1;
          bus.new_state = ST_I;
          state_d       = FILL;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      FILL: begin
        bus.read_req = 1'b1;
        if (bus.ace_ready) begin
          bus.write_from_interconnect = 1'b1;
          bus.state_sel               = 1'b1;
          bus.new_state               = ST_UC;
          state_d                     = op_q ? UPDATE : DONE;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      INVAL: begin
        bus.invalid_req = 1'b1;
        if (bus.ace_ready) state_d = UPDATE;
        else if (abort)    state_d = IDLE;
      end
      UPDATE: begin
        bus.write_from_cpu = 1'b1;
        bus.state_sel      = 1'b1;
        bus.new_state      = ST_UD;
        state_d            = DONE;
      end
      DONE: begin
        bus.cache_complete = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/cache_controller_q.md
Name: cache_controller_q

Overview:
- Parametrised successor of the single-request cache line controller.
- Accepts CPU read/write requests into a QUEUE_DEPTH-entry FIFO and processes them one at a time.
- Per request: tag lookup, then dirty-victim write-back, line fill or upgrade-invalidate over ACE-style request/ready handshakes.
- Drives data/state array update strobes; sits between the CPU port and the ACE interconnect master.

Parameters:
ADDR_W, 32, width of request address
QUEUE_DEPTH, 4, request FIFO entries (power of two, >=2)
TIMEOUT_W, 8, width of ACE wait timeout counter (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
cpu_req_valid  input  1  CPU request valid
cpu_req_op  input  1  0=read, 1=write
cpu_req_addr  input  ADDR_W  request address
cache_ready  output  1  FIFO can accept (= not full)
lookup_valid  output  1  tag lookup strobe
lookup_addr  output  ADDR_W  address being looked up/serviced
cache_hit  input  1  lookup result, valid cycle after lookup_valid
line_state  input  3  line state, valid with cache_hit: 000 I, 001 UD, 010 UC, 011 SD, 100 SC
read_req  output  1  ACE line fill request
write_req  output  1  ACE dirty write-back request
invalid_req  output  1  ACE MakeUnique/invalidate request
ace_ready  input  1  interconnect completion for the active request
write_from_cpu  output  1  data array write from CPU
write_from_interconnect  output  1  data array write from fill data
state_sel  output  1  state array write enable
new_state  output  3  state written when state_sel=1
cache_complete  output  1  one-cycle pulse: current request retired
cache_error  output  1  one-cycle pulse: request aborted (optional feature only, else tied 0)

Behaviour:
- Reset: all outputs 0 except cache_ready=1; FIFO emptied; FSM=IDLE; new_state=000.
- FIFO: enqueue when cpu_req_valid && cache_ready. cache_ready=0 when count==QUEUE_DEPTH; no same-cycle bypass when full. Count width clog2(QUEUE_DEPTH+1); pointers wrap modulo QUEUE_DEPTH. Enqueue and dequeue in the same cycle leave count unchanged.
- FSM states: IDLE, LOOKUP, DECIDE, WB, FILL, INVAL, UPDATE, DONE.
- IDLE: if FIFO non-empty, pop head into op/addr regs, go to LOOKUP.
- LOOKUP: lookup_valid=1 for one cycle, lookup_addr=addr, go to DECIDE.
- DECIDE: sample cache_hit and line_state. A hit with line_state==000 is treated as a miss.
  - Read hit: go to DONE; no state write.
  - Write hit, UD/UC: go to UPDATE.
  - Write hit, SD/SC: go to INVAL.
  - Miss, victim UD or SD: go to WB.
  - Miss, otherwise: go to FILL.
- WB: write_req held high until ace_ready sampled 1. That cycle: state_sel=1, new_state=000; go to FILL.
- FILL: read_req held high until ace_ready. That cycle: write_from_interconnect=1, state_sel=1, new_state=010. Read goes to DONE; write goes to UPDATE.
- INVAL: invalid_req held high until ace_ready; then go to UPDATE.
- UPDATE: one cycle, write_from_cpu=1, state_sel=1, new_state=001; go to DONE.
- DONE: cache_complete=1 for one cycle; go to IDLE. Next pop occurs the cycle after DONE.
- Latencies with ace_ready=1 immediately:
  - Read hit: pop to cache_complete = 3 cycles.
  - Write hit UD: 4 cycles.
- Request outputs are mutually exclusive; at most one of read_req/write_req/invalid_req high in any cycle.
- ace_ready outside WB/FILL/INVAL is ignored.
- Reset mid-operation: outstanding ACE request dropped, FIFO contents discarded, no cache_complete.

Optional Feature:
- Macro CACHE_CTRL_TIMEOUT_EN.
- Defined: a TIMEOUT_W-bit counter clears on entry to WB/FILL/INVAL and increments each waiting cycle. On reaching all-ones without ace_ready:
  - request drops, cache_error pulses 1 cycle, no state write;
  - FSM goes to IDLE; the request is not retried and no cache_complete is issued.
- ace_ready in the same cycle as the counter reaching all-ones wins (normal completion).
- Undefined: no counter, cache_error tied 0, waits are unbounded.

Test Plan:
- Reset, push read 0x100, hit=1, state=010 -> lookup_valid at pop+1, cache_complete at pop+3, no req/state_sel.
- Write 0x200, hit=1, state=100, ace_ready after 5 cycles -> invalid_req high 5 cycles, then write_from_cpu=1, state_sel=1, new_state=001, then cache_complete.
- Read 0x300 miss, state=001, ace_ready=1 each wait -> write_req then new_state=000; read_req then write_from_interconnect=1, new_state=010; cache_complete; never two reqs together.
- Push 5 requests back-to-back with FSM stalled (ace_ready=0) -> cache_ready=0 after 4th accepted entry; 5th held; all retire in FIFO order once ace_ready=1.
- Assert reset during FILL with 2 queued -> next cycle all outputs 0, cache_ready=1, no cache_complete for dropped requests.
- CACHE_CTRL_TIMEOUT_EN, TIMEOUT_W=4, ace_ready=0 -> read_req high 15 cycles, cache_error pulse, FSM returns to IDLE, next queued request proceeds.
